// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and width defaults for the I2C transmit path
package i2c_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 8;
    typedef enum logic [2:0] {IDLE, FETCH, WAIT_DATA, PRESENT, DONE} drain_state_e;
endpackage

// File: rtl/i2c_tx_drain_if.sv
// i2c_tx_drain_if: control, FIFO read port and transmitter handshake of the drain block
interface i2c_tx_drain_if
    import i2c_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) ();
    logic              start;
    logic [CNT_W-1:0]  byte_count;
    logic              abort;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_r_data;
    logic              fifo_r_enable;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic              done;
    logic              underflow;
    modport master (
        output start, byte_count, abort, fifo_empty, fifo_r_data, tx_ready,
        input  fifo_r_enable, tx_data, tx_valid, busy, done, underflow
    );
    modport slave (
        input  start, byte_count, abort, fifo_empty, fifo_r_data, tx_ready,
        output fifo_r_enable, tx_data, tx_valid, busy, done, underflow
    );
endinterface

// File: rtl/i2c_stall_timer.sv
// i2c_stall_timer: counts consecutive stall cycles and flags the cycle that reaches LIMIT
module i2c_stall_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count,
    output logic expired
);
    localparam int TW = $clog2(LIMIT + 1);
    logic [TW-1:0] cnt;
    assign expired = count && (cnt == TW'(LIMIT - 1));
    always_ff @(posedge clk or posedge rst)
        if (rst)
            cnt <= '0;
        else if (clear || expired)
            cnt <= '0;
        else if (count)
            cnt <= cnt + TW'(1);
endmodule

// File: rtl/i2c_tx_drain.sv
// i2c_tx_drain: pops byte_count bytes from a FIFO and hands them to an I2C transmitter
module i2c_tx_drain
    import i2c_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int STALL_LIMIT = 255
) (
    input logic           clk,
    input logic           rst,
    i2c_tx_drain_if.slave bus
);
    drain_state_e      state, state_nxt;
    logic [CNT_W-1:0]  remaining;
    logic [DATA_W-1:0] tx_data_q;
    logic              hs, stall, expired;
    assign hs    = (state == PRESENT) && bus.tx_ready && !bus.abort;
    assign stall = (state == FETCH) && bus.fifo_empty && !bus.abort;
    i2c_stall_timer #(.LIMIT(STALL_LIMIT)) u_stall (
        .clk     (clk),
        .rst     (rst),
        .clear   (!stall),
        .count   (stall),
        .expired (expired)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      state_nxt = !bus.start ? IDLE : (bus.byte_count != '0 ? FETCH : DONE);
            FETCH:     state_nxt = !bus.fifo_empty ? WAIT_DATA : (expired ? IDLE : FETCH);
            WAIT_DATA: state_nxt = PRESENT;
            PRESENT:   state_nxt = !bus.tx_ready ? PRESENT : (remaining <= CNT_W'(1) ? DONE : FETCH);
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
        if (bus.abort)
            state_nxt = IDLE;
    end
    always_comb begin
        bus.fifo_r_enable = (state == FETCH) && !bus.fifo_empty && !bus.abort;
        bus.tx_valid      = state == PRESENT;
        bus.tx_data       = tx_data_q;
        bus.busy          = state != IDLE;
        bus.done          = (state == DONE) && !bus.abort;
        bus.underflow     = expired;
    end
    // remaining saturates at zero so a stray handshake can never wrap it
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            remaining <= '0;
            tx_data_q <= '0;
        end else begin
            if (state == IDLE && bus.start && !bus.abort)
                remaining <= bus.byte_count;
            else if (hs && remaining != '0)
                remaining <= remaining - CNT_W'(1);
            if (state == WAIT_DATA)
                tx_data_q <= bus.fifo_r_data;
        end
endmodule

// File: tb/tb_i2c_tx_drain.sv
// tb_i2c_tx_drain: table-driven and directed checks of the FIFO-to-transmitter drain block
module tb_i2c_tx_drain;
    import i2c_pkg::*;
    localparam int DW = 8;
    localparam int CW = 8;
    localparam int SL = 4;
    typedef struct {
        logic          start;
        logic [CW-1:0] bc;
        logic          ready;
        logic [12:0]   exp;
    } vec_t;
    logic tb_w_clk = 1'b0;
    logic rst;
    int checks = 0, errors = 0;
    int pops = 0, dones = 0, ufs = 0;
    int rp = 0, wp = 0;
    int p0, d0, u0;
    logic [7:0] mem [0:31];
    vec_t v [21];
    always #5 tb_w_clk = ~tb_w_clk;
    i2c_tx_drain_if #(.DATA_W(DW), .CNT_W(CW)) bus ();
    i2c_tx_drain #(.DATA_W(DW), .CNT_W(CW), .STALL_LIMIT(SL)) dut (
        .clk (tb_w_clk),
        .rst (rst),
        .bus (bus)
    );
    assign bus.fifo_empty = (rp == wp);
    // FIFO model with one-cycle read latency, plus pop/done/underflow monitors
    always @(posedge tb_w_clk) begin
        if (bus.fifo_r_enable) begin
            bus.fifo_r_data <= mem[rp];
            rp <= rp + 1;
            pops++;
            checks++;
            if (bus.fifo_empty) begin
                errors++;
                $display("FAIL pop_while_empty: fifo_r_enable=1 with fifo_empty=1 at %0t", $time);
            end
        end
        if (bus.done) dones++;
        if (bus.underflow) ufs++;
    end
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
    function automatic logic [12:0] e(input logic ren, input logic vld, input logic [7:0] d,
                                      input logic b, input logic dn, input logic u);
        return {ren, vld, d, b, dn, u};
    endfunction
    function automatic logic [12:0] outs();
        return {bus.fifo_r_enable, bus.tx_valid, bus.tx_data, bus.busy, bus.done, bus.underflow};
    endfunction
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge tb_w_clk);
        #1;
    endtask
    task automatic push(input logic [7:0] d);
        mem[wp] = d;
        wp++;
    endtask
    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.byte_count = '0;
        bus.abort = 1'b0;
        bus.tx_ready = 1'b0;
        bus.fifo_r_data = '0;
        v[0]  = '{1'b1, 8'd3, 1'b1, e(0, 0, 8'h00, 0, 0, 0)};
        v[1]  = '{1'b0, 8'd0, 1'b1, e(1, 0, 8'h00, 1, 0, 0)};
        v[2]  = '{1'b0, 8'd0, 1'b1, e(0, 0, 8'h00, 1, 0, 0)};
        v[3]  = '{1'b0, 8'd0, 1'b1, e(0, 1, 8'h11, 1, 0, 0)};
        v[4]  = '{1'b1, 8'd5, 1'b1, e(1, 0, 8'h11, 1, 0, 0)};
        v[5]  = '{1'b0, 8'd0, 1'b1, e(0, 0, 8'h11, 1, 0, 0)};
        v[6]  = '{1'b0, 8'd0, 1'b1, e(0, 1, 8'h22, 1, 0, 0)};
        v[7]  = '{1'b0, 8'd0, 1'b1, e(1, 0, 8'h22, 1, 0, 0)};
        v[8]  = '{1'b0, 8'd0, 1'b1, e(0, 0, 8'h22, 1, 0, 0)};
        v[9]  = '{1'b0, 8'd0, 1'b1, e(0, 1, 8'h33, 1, 0, 0)};
        v[10] = '{1'b0, 8'd0, 1'b1, e(0, 0, 8'h33, 1, 1, 0)};
        v[11] = '{1'b0, 8'd0, 1'b1, e(0, 0, 8'h33, 0, 0, 0)};
        v[12] = '{1'b1, 8'd0, 1'b1, e(0, 0, 8'h33, 0, 0, 0)};
        v[13] = '{1'b0, 8'd0, 1'b1, e(0, 0, 8'h33, 1, 1, 0)};
        v[14] = '{1'b0, 8'd0, 1'b1, e(0, 0, 8'h33, 0, 0, 0)};
        v[15] = '{1'b1, 8'd1, 1'b1, e(0, 0, 8'h33, 0, 0, 0)};
        for (int i = 16; i < 19; i++)
            v[i] = '{1'b0, 8'd0, 1'b1, e(0, 0, 8'h33, 1, 0, 0)};
        v[19] = '{1'b0, 8'd0, 1'b1, e(0, 0, 8'h33, 1, 0, 1)};
        v[20] = '{1'b0, 8'd0, 1'b1, e(0, 0, 8'h33, 0, 0, 0)};
        push(8'h11);
        push(8'h22);
        push(8'h33);
        repeat (2) tick();
        chk("reset_outputs", 32'(outs()), 32'(e(0, 0, 8'h00, 0, 0, 0)));
        rst = 1'b0;
        tick();
        // three-byte drain, zero-length start, then stall into underflow
        for (int i = 0; i < 21; i++) begin
            bus.start = v[i].start;
            bus.byte_count = v[i].bc;
            bus.tx_ready = v[i].ready;
            #1;
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(v[i].exp));
            tick();
        end
        chk("vec_pops", pops, 3);
        chk("vec_dones", dones, 2);
        chk("vec_underflows", ufs, 1);
        // receiver stalled: byte held stable, no second pop
        push(8'hA5);
        push(8'h5A);
        p0 = pops;
        d0 = dones;
        bus.start = 1'b1;
        bus.byte_count = 8'd2;
        bus.tx_ready = 1'b0;
        tick();
        bus.start = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("stall_hold%0d", i), {bus.tx_valid, bus.tx_data}, {1'b1, 8'hA5});
            tick();
        end
        chk("stall_one_pop", pops - p0, 1);
        bus.tx_ready = 1'b1;
        repeat (3) tick();
        chk("stall_byte2", {bus.tx_valid, bus.tx_data}, {1'b1, 8'h5A});
        tick();
        chk("stall_done", bus.done, 1'b1);
        tick();
        chk("stall_idle", bus.busy, 1'b0);
        chk("stall_totals", {pops - p0, dones - d0}, {32'd2, 32'd1});
        // abort while presenting byte 2 of 5
        for (int i = 1; i <= 5; i++) push(8'(i));
        p0 = pops;
        d0 = dones;
        u0 = ufs;
        bus.start = 1'b1;
        bus.byte_count = 8'd5;
        tick();
        bus.start = 1'b0;
        repeat (2) tick();
        chk("abort_b1", {bus.tx_valid, bus.tx_data}, {1'b1, 8'h01});
        repeat (3) tick();
        chk("abort_b2", {bus.tx_valid, bus.tx_data}, {1'b1, 8'h02});
        bus.abort = 1'b1;
        bus.tx_ready = 1'b0;
        tick();
        bus.abort = 1'b0;
        chk("abort_idle", {bus.busy, bus.tx_valid}, 2'b00);
        repeat (2) tick();
        chk("abort_totals", {pops - p0, dones - d0, ufs - u0}, {32'd2, 32'd0, 32'd0});
        // abort in FETCH suppresses the pop; abort beats a simultaneous start
        p0 = pops;
        bus.start = 1'b1;
        bus.byte_count = 8'd1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b1;
        #1;
        chk("abort_fetch_no_pop", {bus.busy, bus.fifo_r_enable}, 2'b10);
        tick();
        chk("abort_fetch_idle", bus.busy, 1'b0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("abort_beats_start", bus.busy, 1'b0);
        chk("abort_fetch_pops", pops - p0, 0);
        // reset mid-drain, then a clean single-byte drain
        d0 = dones;
        u0 = ufs;
        bus.start = 1'b1;
        bus.byte_count = 8'd3;
        bus.tx_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (2) tick();
        chk("rst_pre_b3", {bus.tx_valid, bus.tx_data}, {1'b1, 8'h03});
        rst = 1'b1;
        #1;
        chk("rst_async", 32'(outs()), 32'(e(0, 0, 8'h00, 0, 0, 0)));
        tick();
        chk("rst_held", 32'(outs()), 32'(e(0, 0, 8'h00, 0, 0, 0)));
        rst = 1'b0;
        bus.start = 1'b1;
        bus.byte_count = 8'd1;
        tick();
        bus.start = 1'b0;
        #1;
        chk("rst_fetch", {bus.fifo_r_enable, bus.busy}, 2'b11);
        repeat (2) tick();
        chk("rst_b4", {bus.tx_valid, bus.tx_data}, {1'b1, 8'h04});
        tick();
        chk("rst_done", {bus.done, bus.tx_valid}, 2'b10);
        tick();
        chk("rst_idle", bus.busy, 1'b0);
        chk("rst_totals", {dones - d0, ufs - u0}, {32'd1, 32'd0});
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/i2c_tx_drain.md
I2C_TX_DRAIN -- requirements
Module: i2c_tx_drain

Interface
REQ-001 Parameter DATA_W, default 8, byte width of FIFO read data and the tx_data output.
REQ-002 Parameter CNT_W, default 8, width of the byte_count input and the remaining-bytes counter.
REQ-003 Parameter STALL_LIMIT, default 255, number of consecutive empty-FIFO cycles tolerated before an underflow is declared.
REQ-004 clk  input  1  single clock; all state is updated on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to drain byte_count bytes.
REQ-007 byte_count  input  CNT_W  number of bytes to drain; sampled only when start is accepted.
REQ-008 abort  input  1  synchronous cancel of the current drain.
REQ-009 fifo_empty  input  1  empty flag from the upstream FIFO read port.
REQ-010 fifo_r_data  input  DATA_W  FIFO read data, valid the cycle after a fifo_r_enable pulse.
REQ-011 fifo_r_enable  output  1  one-cycle FIFO pop strobe.
REQ-012 tx_data  output  DATA_W  byte presented to the downstream I2C transmitter.
REQ-013 tx_valid  output  1  tx_data holds a valid byte.
REQ-014 tx_ready  input  1  downstream accepts tx_data in a cycle where tx_valid and tx_ready are both high.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse when all requested bytes have been handed off.
REQ-017 underflow  output  1  one-cycle pulse when the stall limit is reached.

Function
REQ-018 The FSM SHALL have the states IDLE, FETCH, WAIT_DATA, PRESENT and DONE.
REQ-019 IDLE: start with byte_count>0 loads the remaining counter and moves to FETCH; start with byte_count==0 moves to DONE; start while busy is ignored.
REQ-020 FETCH, fifo_empty low: assert fifo_r_enable for exactly one cycle, clear the stall counter, move to WAIT_DATA.
REQ-021 FETCH, fifo_empty high: no pop; increment the stall counter; at STALL_LIMIT, pulse underflow and return to IDLE without pulsing done.
REQ-022 WAIT_DATA: register fifo_r_data into tx_data, move to PRESENT; tx_valid rises in the first PRESENT cycle.
REQ-023 PRESENT: hold tx_valid high and tx_data stable until tx_ready is high.
REQ-024 PRESENT, on handshake: decrement remaining; if the result is 0, move to DONE with tx_valid low; otherwise move to FETCH.
REQ-025 DONE: pulse done for one cycle, then move to IDLE.
REQ-026 Minimum throughput SHALL be one byte per 3 cycles with tx_ready held high.
REQ-027 abort in any state SHALL force IDLE on the next edge, drop tx_valid, suppress fifo_r_enable in that cycle, and produce no done or underflow pulse.
REQ-028 abort and start in the same cycle: abort wins and start is dropped.
REQ-029 fifo_r_enable SHALL never be asserted while fifo_empty is high.
REQ-030 The remaining counter SHALL never wrap below 0.

Reset
REQ-031 On rst the block SHALL enter IDLE.
REQ-032 On rst, fifo_r_enable, tx_valid, busy, done and underflow SHALL be 0.
REQ-033 On rst, tx_data, the remaining counter and the stall counter SHALL be 0.
REQ-034 Reset asserted mid-drain SHALL discard the transfer with no done or underflow pulse.

Structure
REQ-035 The state enum and the DATA_W/CNT_W defaults SHALL live in the shared i2c_pkg package.
REQ-036 The stall counter SHALL be the sub-module i2c_stall_timer, with inputs clear and count and output expired.

Verification
REQ-037 Write 0x11, 0x22, 0x33 to the FIFO; start with byte_count=3 and tx_ready=1 -> tx_data 0x11, 0x22, 0x33 in order, 3 pops, done 1 cycle after the last handshake.
REQ-038 byte_count=2, tx_ready held low for 10 cycles -> tx_valid high and tx_data stable throughout, no second pop.
REQ-039 FIFO empty, start with byte_count=1, STALL_LIMIT=4 -> underflow pulse after 4 FETCH cycles, no pop, busy low after.
REQ-040 abort during PRESENT of byte 2 of 5 -> next cycle IDLE, tx_valid=0, exactly 2 pops total, no done.
REQ-041 start with byte_count=0 -> done pulse, no pop, tx_valid never high.
REQ-042 rst mid-drain, then a new start with byte_count=1 -> all outputs 0 during reset, then normal single-byte drain.
